// File: rtl/vga_timing_gen.sv
// VGA timing generator with double-buffered timing registers.
// Staged values written through cfg_* are swapped into the active set at the next frame end after a commit.
module vga_timing_gen #(
    parameter int W              = 11,
    parameter int D_H_VIEW       = 640,
    parameter int D_H_SYNC_START = 656,
    parameter int D_H_SYNC_END   = 752,
    parameter int D_H_MAX        = 799,
    parameter int D_V_VIEW       = 480,
    parameter int D_V_SYNC_START = 490,
    parameter int D_V_SYNC_END   = 492,
    parameter int D_V_MAX        = 524,
    parameter int D_HPOL         = 0,
    parameter int D_VPOL         = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_we,
    input  logic [2:0]   cfg_addr,
    input  logic [W-1:0] cfg_wdata,
    input  logic [1:0]   cfg_pol,
    input  logic         cfg_commit,
    output logic [W-1:0] o_hpos,
    output logic [W-1:0] o_vpos,
    output logic         o_hsync,
    output logic         o_vsync,
    output logic         o_hmax,
    output logic         o_vmax,
    output logic         o_visible,
    output logic         o_frame_start,
    output logic         o_cfg_pending,
    output logic [7:0]   o_frame_count
);

    localparam int A_H_VIEW = 0;
    localparam int A_H_SS   = 1;
    localparam int A_H_SE   = 2;
    localparam int A_H_MAX  = 3;
    localparam int A_V_VIEW = 4;
    localparam int A_V_SS   = 5;
    localparam int A_V_SE   = 6;
    localparam int A_V_MAX  = 7;

    localparam logic [W-1:0] DFLT [8] = '{
        W'(D_H_VIEW), W'(D_H_SYNC_START), W'(D_H_SYNC_END), W'(D_H_MAX),
        W'(D_V_VIEW), W'(D_V_SYNC_START), W'(D_V_SYNC_END), W'(D_V_MAX)
    };
    localparam logic [1:0] DFLT_POL = {1'(D_VPOL), 1'(D_HPOL)};

    logic [W-1:0] stg_q [8];
    logic [W-1:0] act_q [8];
    logic [1:0]   stg_pol_q, act_pol_q;
    logic [W-1:0] hpos_q, hpos_d;
    logic [W-1:0] vpos_q, vpos_d;
    logic         pending_q, pending_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]   stg_we;

    logic hmax, vmax, frame_end, swap;
    logic hs_int, vs_int;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_we
            assign stg_we[gi] = cfg_we && (cfg_addr == 3'(gi));
        end
    endgenerate

    assign hmax      = (hpos_q >= act_q[A_H_MAX]);
    assign vmax      = (vpos_q >= act_q[A_V_MAX]);
    assign frame_end = hmax && vmax;
    assign swap      = frame_end && pending_q;

    // An empty window (END <= START) can never satisfy both bounds, so no special case is needed.
    assign hs_int = (hpos_q >= act_q[A_H_SS]) && (hpos_q < act_q[A_H_SE]);
    assign vs_int = (vpos_q >= act_q[A_V_SS]) && (vpos_q < act_q[A_V_SE]);

    always_comb begin
        hpos_d      = hmax ? '0 : hpos_q + W'(1);
        vpos_d      = vpos_q;
        if (hmax) begin
            vpos_d = vmax ? '0 : vpos_q + W'(1);
        end
        pending_d   = pending_q;
        if (swap) begin
            pending_d = 1'b0;
        end
        // A commit landing on the swap edge re-arms for the following frame.
        if (cfg_commit) begin
            pending_d = 1'b1;
        end
        frame_cnt_d = frame_end ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q      <= '0;
            vpos_q      <= '0;
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
            stg_pol_q   <= DFLT_POL;
            act_pol_q   <= DFLT_POL;
            for (int i = 0; i < 8; i++) begin
                stg_q[i] <= DFLT[i];
                act_q[i] <= DFLT[i];
            end
        end else begin
            hpos_q      <= hpos_d;
            vpos_q      <= vpos_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            if (cfg_commit) begin
                stg_pol_q <= cfg_pol;
            end
            if (swap) begin
                act_pol_q <= stg_pol_q;
            end
            for (int i = 0; i < 8; i++) begin
                if (stg_we[i]) begin
                    stg_q[i] <= cfg_wdata;
                end
                if (swap) begin
                    act_q[i] <= stg_q[i];
                end
            end
        end
    end

    assign o_hpos        = hpos_q;
    assign o_vpos        = vpos_q;
    assign o_hmax        = hmax;
    assign o_vmax        = vmax;
    assign o_visible     = (hpos_q < act_q[A_H_VIEW]) && (vpos_q < act_q[A_V_VIEW]);
    assign o_hsync       = ~(hs_int ^ act_pol_q[0]);
    assign o_vsync       = ~(vs_int ^ act_pol_q[1]);
    assign o_frame_start = (hpos_q == '0) && (vpos_q == '0);
    assign o_cfg_pending = pending_q;
    assign o_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a reference model predicts every cycle's outputs,
// a monitor compares them, and directed scenarios plus random cfg traffic drive the block.
module tb_vga_timing_gen;

    localparam int W = 11;
    // Reduced reset timing so several frames fit in a short run.
    localparam int TH_VIEW = 16, TH_SS = 18, TH_SE = 21, TH_MAX = 24;
    localparam int TV_VIEW = 6,  TV_SS = 7,  TV_SE = 9,  TV_MAX = 10;
    localparam int FRAME_DEF = (TH_MAX + 1) * (TV_MAX + 1);

    typedef struct packed {
        logic [W-1:0] hpos;
        logic [W-1:0] vpos;
        logic         hsync;
        logic         vsync;
        logic         hmax;
        logic         vmax;
        logic         visible;
        logic         fstart;
        logic         pend;
        logic [7:0]   fc;
    } obs_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cfg_we = 1'b0;
    logic [2:0]   cfg_addr = '0;
    logic [W-1:0] cfg_wdata = '0;
    logic [1:0]   cfg_pol = '0;
    logic         cfg_commit = 1'b0;
    logic [W-1:0] o_hpos, o_vpos;
    logic         o_hsync, o_vsync, o_hmax, o_vmax, o_visible, o_frame_start, o_cfg_pending;
    logic [7:0]   o_frame_count;

    int checks = 0;
    int errors = 0;

    vga_timing_gen #(
        .W(W),
        .D_H_VIEW(TH_VIEW), .D_H_SYNC_START(TH_SS), .D_H_SYNC_END(TH_SE), .D_H_MAX(TH_MAX),
        .D_V_VIEW(TV_VIEW), .D_V_SYNC_START(TV_SS), .D_V_SYNC_END(TV_SE), .D_V_MAX(TV_MAX),
        .D_HPOL(0), .D_VPOL(0)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_pol(cfg_pol), .cfg_commit(cfg_commit),
        .o_hpos(o_hpos), .o_vpos(o_vpos), .o_hsync(o_hsync), .o_vsync(o_vsync),
        .o_hmax(o_hmax), .o_vmax(o_vmax), .o_visible(o_visible),
        .o_frame_start(o_frame_start), .o_cfg_pending(o_cfg_pending),
        .o_frame_count(o_frame_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int       m_h, m_v, m_fc;
    int       m_stg [8];
    int       m_act [8];
    logic [1:0] m_spol, m_apol;
    bit       m_pend;
    bit       model_ok = 0;
    obs_t     exp_q [$];

    function automatic obs_t model_obs();
        obs_t o;
        bit hs, vs;
        hs = (m_h >= m_act[1]) && (m_h < m_act[2]);
        vs = (m_v >= m_act[5]) && (m_v < m_act[6]);
        o.hpos    = W'(m_h);
        o.vpos    = W'(m_v);
        o.hsync   = m_apol[0] ? hs : !hs;
        o.vsync   = m_apol[1] ? vs : !vs;
        o.hmax    = (m_h >= m_act[3]);
        o.vmax    = (m_v >= m_act[7]);
        o.visible = (m_h < m_act[0]) && (m_v < m_act[4]);
        o.fstart  = (m_h == 0) && (m_v == 0);
        o.pend    = m_pend;
        o.fc      = 8'(m_fc);
        return o;
    endfunction

    always @(posedge clk) begin
        int  nact [8];
        logic [1:0] napol;
        bit  fe, line_end;
        if (reset) begin
            m_h = 0; m_v = 0; m_fc = 0; m_pend = 0;
            m_stg = '{TH_VIEW, TH_SS, TH_SE, TH_MAX, TV_VIEW, TV_SS, TV_SE, TV_MAX};
            m_act = m_stg;
            m_spol = 2'b00; m_apol = 2'b00;
            model_ok = 1;
        end else if (model_ok) begin
            line_end = (m_h >= m_act[3]);
            fe       = line_end && (m_v >= m_act[7]);
            nact  = m_act;
            napol = m_apol;
            if (fe && m_pend) begin
                nact  = m_stg;
                napol = m_spol;
                m_pend = 0;
            end
            if (cfg_commit) begin
                m_pend = 1;
                m_spol = cfg_pol;
            end
            if (cfg_we) m_stg[cfg_addr] = int'(cfg_wdata);
            if (fe) m_fc = (m_fc + 1) % 256;
            if (line_end) begin
                m_h = 0;
                m_v = (m_v >= m_act[7]) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
            m_act  = nact;
            m_apol = napol;
        end
        if (model_ok) exp_q.push_back(model_obs());
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{o_hpos, o_vpos, o_hsync, o_vsync, o_hmax, o_vmax, o_visible,
                  o_frame_start, o_cfg_pending, o_frame_count};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_compare t=%0t actual hpos=%0d vpos=%0d hs=%b vs=%b hm=%b vm=%b vis=%b fs=%b pend=%b fc=%0d required hpos=%0d vpos=%0d hs=%b vs=%b hm=%b vm=%b vis=%b fs=%b pend=%b fc=%0d",
                         $time, a.hpos, a.vpos, a.hsync, a.vsync, a.hmax, a.vmax, a.visible, a.fstart, a.pend, a.fc,
                         e.hpos, e.vpos, e.hsync, e.vsync, e.hmax, e.vmax, e.visible, e.fstart, e.pend, e.fc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic wr(input int addr, input int data);
        cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_wdata = W'(data);
        $display("cfg write addr=%0d data=%0d t=%0t", addr, data, $time);
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic commit(input logic [1:0] pol);
        cfg_commit = 1'b1; cfg_pol = pol;
        $display("cfg commit pol=%b t=%0t", pol, $time);
        cyc();
        cfg_commit = 1'b0;
    endtask

    // Advances until the frame-end cycle is showing; n = cycles advanced.
    task automatic wait_fe(input string name, output int n);
        bit ok = 0;
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            if (o_hmax && o_vmax) begin ok = 1; break; end
            cyc();
            n++;
        end
        if (!ok) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int n, lows, maxh;
        repeat (3) cyc();
        reset = 1'b0;

        // first cycle after reset
        chk("rst_hpos", o_hpos, 0);
        chk("rst_vpos", o_vpos, 0);
        chk("rst_frame_start", o_frame_start, 1);
        chk("rst_visible", o_visible, 1);
        chk("rst_hsync", o_hsync, 1);
        chk("rst_vsync", o_vsync, 1);
        chk("rst_hmax", o_hmax, 0);
        chk("rst_vmax", o_vmax, 0);
        chk("rst_pending", o_cfg_pending, 0);
        chk("rst_fc", o_frame_count, 0);

        // two default frames
        wait_fe("def1", n);
        chk("def1_len", n, FRAME_DEF - 1);
        chk("def1_fc", o_frame_count, 0);
        cyc();
        chk("def1_fc_after", o_frame_count, 1);
        wait_fe("def2", n);
        chk("def2_len", n, FRAME_DEF - 1);
        cyc();
        chk("def2_fc_after", o_frame_count, 2);

        // mid-frame reconfiguration with active-high vsync
        repeat (40) cyc();
        wr(3, 29); wr(0, 20); wr(1, 22); wr(2, 25);
        wr(4, 8);  wr(5, 9);  wr(6, 11); wr(7, 12);
        commit(2'b10);
        chk("recfg_pending", o_cfg_pending, 1);
        wait_fe("recfg_old", n);
        chk("recfg_old_hpos", o_hpos, TH_MAX);
        chk("recfg_old_vpos", o_vpos, TV_MAX);
        chk("recfg_old_pending", o_cfg_pending, 1);
        cyc();
        chk("recfg_new_pending", o_cfg_pending, 0);
        chk("recfg_new_fstart", o_frame_start, 1);
        wait_fe("recfg_new", n);
        chk("recfg_new_len", n, 30 * 13 - 1);

        // commit and write on the frame-end cycle itself
        cfg_commit = 1'b1; cfg_pol = 2'b10;
        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = W'(35);
        $display("cfg commit+write addr=3 data=35 at frame end t=%0t", $time);
        cyc();
        cfg_commit = 1'b0; cfg_we = 1'b0;
        chk("fe_commit_pending", o_cfg_pending, 1);
        wait_fe("fe_commit_noswap", n);
        chk("fe_commit_noswap_len", n, 30 * 13 - 1);
        cyc();
        chk("fe_commit_swapped_pending", o_cfg_pending, 0);
        wait_fe("fe_commit_swap", n);
        chk("fe_commit_swap_len", n, 36 * 13 - 1);

        // zero-length hsync window
        wr(1, 5); wr(2, 5);
        commit(2'b10);
        wait_fe("nosync_a", n);
        cyc();
        lows = 0;
        for (int i = 0; i < 5000; i++) begin
            if (!o_hsync) lows++;
            if (o_hmax && o_vmax) break;
            cyc();
        end
        chk("nosync_hsync_active_cycles", lows, 0);

        // shrink H_MAX from 35 to 9
        wr(3, 9);
        commit(2'b10);
        wait_fe("shrink", n);
        chk("shrink_at_hpos", o_hpos, 35);
        chk("shrink_at_vpos", o_vpos, 12);
        cyc();
        maxh = 0;
        for (int i = 0; i < 5000; i++) begin
            if (int'(o_hpos) > maxh) maxh = int'(o_hpos);
            if (o_hmax && o_vmax) break;
            cyc();
        end
        chk("shrink_max_hpos", maxh, 9);

        // reset mid-frame with a commit pending
        wr(3, 20);
        commit(2'b11);
        for (int i = 0; i < 5000 && o_vpos != 5; i++) cyc();
        chk("pre_reset_pending", o_cfg_pending, 1);
        reset = 1'b1;
        $display("reset pulse t=%0t", $time);
        cyc();
        reset = 1'b0;
        chk("midrst_hpos", o_hpos, 0);
        chk("midrst_vpos", o_vpos, 0);
        chk("midrst_pending", o_cfg_pending, 0);
        wait_fe("midrst", n);
        chk("midrst_len", n, FRAME_DEF - 1);

        // random configuration traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                cfg_we = 1'b1;
                cfg_addr = 3'($urandom_range(0, 7));
                cfg_wdata = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 40));
                $display("rand write addr=%0d data=%0d t=%0t", cfg_addr, cfg_wdata, $time);
            end
            if ($urandom_range(0, 149) == 0) begin
                cfg_commit = 1'b1;
                cfg_pol = 2'($urandom_range(0, 3));
                $display("rand commit pol=%b t=%0t", cfg_pol, $time);
            end
            if ($urandom_range(0, 1999) == 0) begin
                reset = 1'b1;
                $display("rand reset t=%0t", $time);
            end
            cyc();
            cfg_we = 1'b0; cfg_commit = 1'b0; reset = 1'b0;
        end

        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL expose parameter W, default 11, meaning the width of the position counters and timing registers.
REQ-002 The block SHALL expose parameters D_H_VIEW=640, D_H_SYNC_START=656, D_H_SYNC_END=752, D_H_MAX=799, D_V_VIEW=480, D_V_SYNC_START=490, D_V_SYNC_END=492, D_V_MAX=524, D_HPOL=0, D_VPOL=0, meaning the reset timing values; polarity 0 means active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cfg_we  input  1  write strobe for the staged timing register selected by cfg_addr.
REQ-006 cfg_addr  input  3  register select: 0 H_VIEW, 1 H_SYNC_START, 2 H_SYNC_END, 3 H_MAX, 4 V_VIEW, 5 V_SYNC_START, 6 V_SYNC_END, 7 V_MAX.
REQ-007 cfg_wdata  input  W  write data.
REQ-008 cfg_pol  input  2  staged polarity {vpol,hpol}, sampled on cfg_commit.
REQ-009 cfg_commit  input  1  single-cycle request to apply the staged set at the next frame boundary.
REQ-010 o_hpos, o_vpos  output  W each  current pixel and line positions.
REQ-011 o_hsync, o_vsync  output  1 each  sync outputs with the active polarity applied.
REQ-012 o_hmax, o_vmax, o_visible  output  1 each  last pixel of the line, last line of the frame, and pixel inside the view area.
REQ-013 o_frame_start  output  1  high while o_hpos==0 and o_vpos==0.
REQ-014 o_cfg_pending  output  1  a commit is waiting for the frame boundary.
REQ-015 o_frame_count  output  8  count of completed frames, wrapping from 255 to 0.

Function
REQ-016 Two register sets SHALL exist: staged, written via cfg_*, and active, used for timing; each holds 8 W-bit values plus 2 polarity bits.
REQ-017 When cfg_we is high, staged[cfg_addr] SHALL take cfg_wdata at the clock edge; the active set SHALL NOT change.
REQ-018 When cfg_commit is high, the block SHALL set pending to 1 and set the staged polarity to cfg_pol.
REQ-019 The frame-end event SHALL be o_hmax and o_vmax both high; at that edge, if pending==1, the active set SHALL take the staged set and pending SHALL clear.
REQ-020 Simultaneous events at the frame-end edge:
- a cfg_we write lands in the staged set only; the swap uses the pre-write staged values.
- a cfg_commit in the same cycle is not consumed; pending remains 1 for the next frame end.
REQ-021 The horizontal counter SHALL advance as follows:
- hpos increments by 1 each cycle.
- if hpos>=H_MAX (active), hpos becomes 0 on the next edge; the >= comparison prevents runaway after a config change.
REQ-022 The vertical counter SHALL advance only on edges where hpos>=H_MAX:
- vpos becomes 0 if vpos>=V_MAX.
- otherwise vpos increments by 1.
REQ-023 o_hmax SHALL be (hpos>=H_MAX) and o_vmax SHALL be (vpos>=V_MAX), both combinational from the counter registers with zero latency.
REQ-024 o_visible SHALL be (hpos<H_VIEW)&&(vpos<V_VIEW) in the same cycle as the positions.
REQ-025 Sync generation:
- internal hsync is true when H_SYNC_START<=hpos<H_SYNC_END; internal vsync is true when V_SYNC_START<=vpos<V_SYNC_END.
- each output is the internal signal XNOR the polarity bit (pol=1 gives an active-high output), aligned with the same-cycle positions.
REQ-026 If SYNC_END<=SYNC_START, the corresponding sync SHALL never assert; no other validity checks are performed.
REQ-027 o_frame_count SHALL increment on every frame-end edge.
REQ-028 All comparisons SHALL be unsigned W-bit; a zero-length view area (VIEW=0) SHALL keep o_visible at 0.

Reset
REQ-029 While reset is high, at each edge the block SHALL:
- set hpos and vpos to 0, pending to 0 and frame_count to 0.
- load both the staged and active sets with the D_* parameters.
- ignore cfg_we and cfg_commit.
REQ-030 In the first cycle after reset deasserts, the outputs SHALL be: o_frame_start=1, o_visible=1, o_hsync=1, o_vsync=1 (default active-low idle), o_hmax=0, o_vmax=0.
REQ-031 Reset asserted mid-frame or with a commit pending SHALL discard the pending commit and the staged writes.

Verification
REQ-032 Defaults, run 2 frames:
- hpos runs 0..799 and vpos runs 0..524.
- o_hsync is low for hpos 656..751; o_vsync is low for vpos 490..491.
- o_frame_count goes 0->1->2, one step per 420000 cycles.
REQ-033 Mid-frame, write H_MAX=475, H_VIEW=360, H_SYNC_START=380, H_SYNC_END=418, V_VIEW=900, V_SYNC_START=901, V_SYNC_END=904, V_MAX=931, then commit with cfg_pol=2'b10:
- the current frame completes with 640x480 timing and o_cfg_pending=1.
- the next frame uses 476x932 with an active-high vsync, and o_cfg_pending=0.
REQ-034 Assert cfg_commit and cfg_we (addr 3, data 99) in the exact frame-end cycle with nothing pending:
- no swap occurs at that edge.
- the swap occurs at the following frame end with H_MAX=99.
REQ-035 Reset during line 300 with a commit pending:
- the next cycle shows hpos=0, vpos=0, o_cfg_pending=0 and default timing.
REQ-036 Set H_SYNC_END=H_SYNC_START=100 and commit:
- o_hsync stays at its inactive level for an entire frame.
REQ-037 Commit H_MAX=9 while the active H_MAX=799:
- the transition occurs only at (799,524).
- after it, hpos cycles 0..9 and never exceeds 9.
